regfile_param: RTL

Parametrised multi-port register file with per-register reservation (busy) tracking. It generalises the team's fixed 4×8-bit, two-read-port file to configurable width, depth and read-port count, and moves writes onto the rising clock edge. It adds a scoreboard so the control FSM can mark a destination pending at issue and have it cleared automatically at writeback. It sits between the decoder/control FSM and the ALU datapath, and exports its full contents for the display/debug logic.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 46 ++++
 rtl/regfile_param.sv | 80 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DefaultDataW   = 8;
  localparam int unsigned DefaultNumRegs = 4;
  localparam int unsigned DefaultNumRd   = 2;
  localparam int unsigned DefaultAddrW   = $clog2(DefaultNumRegs);

  typedef logic [DefaultAddrW-1:0] regfile_addr_t;

  // Selects can exceed the register count when NUM_REGS is not a power of two.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned num_regs);
    return sel < num_regs;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register mux plus optional write bypass.
// Bypass compare is present only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [NUM_REGS-1:0]        busy_vec,
  input  logic [ADDR_W-1:0]          rd_sel,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_sel,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_busy
);

  logic sel_ok;
  assign sel_ok = sel_valid(32'(rd_sel), NUM_REGS);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (sel_ok) begin
      rd_data = regs_flat[32'(rd_sel)*DATA_W +: DATA_W];
      rd_busy = busy_vec[rd_sel];
    end
`ifdef REGFILE_BYPASS_EN
    // A write in flight clears busy unless a reservation of the same register lands with it.
    if (sel_ok && wr_en && (wr_sel == rd_sel)) begin
      rd_data = wr_data;
      rd_busy = rsv_en && (rsv_sel == rd_sel);
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_sel, wr_data, rsv_en, rsv_sel};
`endif

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned NUM_REGS = DefaultNumRegs,
  parameter int unsigned NUM_RD   = DefaultNumRd,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_sel,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_sel,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic                            wr_ok, rsv_ok, wr_fwd;

  assign wr_ok  = wr_en && sel_valid(32'(wr_sel), NUM_REGS);
  assign rsv_ok = rsv_en && sel_valid(32'(rsv_sel), NUM_REGS);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_sel] = wr_data;
      busy_d[wr_sel] = 1'b0;
    end
    // Applied after the write so a same-register reservation leaves busy set.
    if (rsv_ok) begin
      busy_d[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign regs_flat = regs_q;
  assign busy_vec  = busy_q;

  // Keeps forwarded data off the read ports while reset holds everything at zero.
  assign wr_fwd = wr_en & ~rst;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_rd_port (
      .regs_flat (regs_q),
      .busy_vec  (busy_q),
      .rd_sel    (rd_sel[p*ADDR_W +: ADDR_W]),
      .wr_en     (wr_fwd),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_sel   (rsv_sel),
      .rd_data   (rd_data[p*DATA_W +: DATA_W]),
      .rd_busy   (rd_busy[p])
    );
  end

endmodule
